// File: rtl/univ_shift_reg.sv
// Universal shift register: parallel load, logical/arithmetic shifts,
// rotates, serial in/out, clear, and a saturating shift counter with a
// combinational done flag for word serialisation.
module univ_shift_reg #(
    parameter int              WIDTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [2:0]                 mode,
    input  logic [WIDTH-1:0]           d,
    input  logic                       sin_l,
    input  logic                       sin_r,
    output logic [WIDTH-1:0]           q_out,
    output logic                       sout_l,
    output logic                       sout_r,
    output logic [$clog2(WIDTH+1)-1:0] shift_cnt,
    output logic                       done
);

    // Counter must hold the value WIDTH itself, hence WIDTH+1 states.
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

    typedef enum logic [2:0] {
        MODE_HOLD  = 3'b000,
        MODE_LOAD  = 3'b001,
        MODE_SHL   = 3'b010,
        MODE_SHR   = 3'b011,
        MODE_ROL   = 3'b100,
        MODE_ROR   = 3'b101,
        MODE_ASR   = 3'b110,
        MODE_CLEAR = 3'b111
    } mode_e;

    logic [WIDTH-1:0] q_q, q_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Counter increment that sticks at WIDTH instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        if (c == CNT_MAX) begin
            return c;
        end
        return c + 1'b1;
    endfunction

    // Left shift with a caller-supplied fill bit at the LSB.
    function automatic logic [WIDTH-1:0] shl_fill(input logic [WIDTH-1:0] v,
                                                  input logic             fill);
        return {v[WIDTH-2:0], fill};
    endfunction

    // Right shift with a caller-supplied fill bit at the MSB.
    function automatic logic [WIDTH-1:0] shr_fill(input logic [WIDTH-1:0] v,
                                                  input logic             fill);
        return {fill, v[WIDTH-1:1]};
    endfunction

    // Next-state decode: rst beats en, en beats mode; every mode is defined.
    always_comb begin
        q_d   = q_q;
        cnt_d = cnt_q;
        if (rst) begin
            q_d   = RST_VAL;
            cnt_d = '0;
        end else if (en) begin
            unique case (mode_e'(mode))
                MODE_HOLD: begin
                    q_d   = q_q;
                    cnt_d = cnt_q;
                end
                MODE_LOAD: begin
                    q_d   = d;
                    cnt_d = '0;
                end
                MODE_SHL: begin
                    q_d   = shl_fill(q_q, sin_r);
                    cnt_d = sat_inc(cnt_q);
                end
                MODE_SHR: begin
                    q_d   = shr_fill(q_q, sin_l);
                    cnt_d = sat_inc(cnt_q);
                end
                MODE_ROL: begin
                    q_d   = shl_fill(q_q, q_q[WIDTH-1]);
                    cnt_d = sat_inc(cnt_q);
                end
                MODE_ROR: begin
                    q_d   = shr_fill(q_q, q_q[0]);
                    cnt_d = sat_inc(cnt_q);
                end
                MODE_ASR: begin
                    q_d   = shr_fill(q_q, q_q[WIDTH-1]);
                    cnt_d = sat_inc(cnt_q);
                end
                MODE_CLEAR: begin
                    q_d   = '0;
                    cnt_d = '0;
                end
            endcase
        end
    end

    // State register; reset is folded into the next-state logic above.
    always_ff @(posedge clk) begin
        q_q   <= q_d;
        cnt_q <= cnt_d;
    end

    // Serial outputs expose the bit about to be shifted out before the edge.
    assign q_out     = q_q;
    assign sout_l    = q_q[WIDTH-1];
    assign sout_r    = q_q[0];
    assign shift_cnt = cnt_q;
    assign done      = (cnt_q == CNT_MAX);

endmodule

// File: tb/tb_univ_shift_reg.sv
// Testbench for univ_shift_reg (WIDTH=4, RST_VAL=0): directed scenarios
// followed by randomized traffic, all compared against an arithmetic model.
module tb_univ_shift_reg;

    localparam int W = 4;
    localparam int MOD = 1 << W;
    localparam int HALF = 1 << (W - 1);

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic [2:0]   mode;
    logic [W-1:0] d;
    logic         sin_l;
    logic         sin_r;
    logic [W-1:0] q_out;
    logic         sout_l;
    logic         sout_r;
    logic [2:0]   shift_cnt;
    logic         done;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: register value and shift count as plain integers.
    int mq = 0;
    int mc = 0;

    univ_shift_reg #(.WIDTH(W), .RST_VAL(4'b0000)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .mode      (mode),
        .d         (d),
        .sin_l     (sin_l),
        .sin_r     (sin_r),
        .q_out     (q_out),
        .sout_l    (sout_l),
        .sout_r    (sout_r),
        .shift_cnt (shift_cnt),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference behaviour expressed with integer arithmetic on the value.
    task automatic model_update();
        int sl, sr;
        sl = int'(sin_l);
        sr = int'(sin_r);
        if (rst) begin
            mq = 0;
            mc = 0;
        end else if (en) begin
            case (int'(mode))
                0: ;
                1: begin mq = int'(d); mc = 0; end
                2: begin mq = (mq * 2 + sr) % MOD; mc = (mc < W) ? mc + 1 : W; end
                3: begin mq = mq / 2 + sl * HALF; mc = (mc < W) ? mc + 1 : W; end
                4: begin mq = (mq * 2) % MOD + mq / HALF; mc = (mc < W) ? mc + 1 : W; end
                5: begin mq = mq / 2 + (mq % 2) * HALF; mc = (mc < W) ? mc + 1 : W; end
                6: begin mq = mq / 2 + ((mq >= HALF) ? HALF : 0); mc = (mc < W) ? mc + 1 : W; end
                default: begin mq = 0; mc = 0; end
            endcase
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".q"},    int'(q_out),     mq);
        chk({tag, ".cnt"},  int'(shift_cnt), mc);
        chk({tag, ".done"}, int'(done),      (mc == W) ? 1 : 0);
        chk({tag, ".soutl"}, int'(sout_l),   mq / HALF);
        chk({tag, ".soutr"}, int'(sout_r),   mq % 2);
    endtask

    // Apply the currently driven inputs for one clock, then compare.
    task automatic step(input string tag);
        @(posedge clk);
        model_update();
        #1;
        check_all(tag);
    endtask

    task automatic drive(input logic r, input logic e, input logic [2:0] m,
                         input logic [W-1:0] dv, input logic sl, input logic sr);
        rst = r; en = e; mode = m; d = dv; sin_l = sl; sin_r = sr;
    endtask

    initial begin
        drive(1'b1, 1'b0, 3'b000, '0, 1'b0, 1'b0);

        // Reset for two cycles.
        step("rst0");
        step("rst1");
        chk("rst_q_const", int'(q_out), 0);

        // Load 1011.
        drive(1'b0, 1'b1, 3'b001, 4'b1011, 1'b0, 1'b0);
        step("load");
        chk("load_q_const", int'(q_out), 11);

        // Five SHL with sin_r=0: counter saturates at 4.
        drive(1'b0, 1'b1, 3'b010, 4'b0000, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step("shl");
        chk("shl_sat_const", int'(shift_cnt), 4);
        chk("shl_done_const", int'(done), 1);

        // ROR then ROL from 1011.
        drive(1'b0, 1'b1, 3'b001, 4'b1011, 1'b0, 1'b0);
        step("load2");
        drive(1'b0, 1'b1, 3'b101, 4'b0000, 1'b0, 1'b0);
        step("ror");
        chk("ror_const", int'(q_out), 13);
        drive(1'b0, 1'b1, 3'b100, 4'b0000, 1'b0, 1'b0);
        step("rol");

        // Load 1000, ASR -> 1100, SHR sin_l=0 -> 0110.
        drive(1'b0, 1'b1, 3'b001, 4'b1000, 1'b0, 1'b0);
        step("load3");
        drive(1'b0, 1'b1, 3'b110, 4'b0000, 1'b0, 1'b0);
        step("asr");
        chk("asr_const", int'(q_out), 12);
        drive(1'b0, 1'b1, 3'b011, 4'b0000, 1'b0, 1'b0);
        step("shr");
        chk("shr_const", int'(q_out), 6);

        // en=0 ignores a LOAD of 1111.
        drive(1'b0, 1'b0, 3'b001, 4'b1111, 1'b1, 1'b1);
        step("hold_en0");

        // CLEAR.
        drive(1'b0, 1'b1, 3'b111, 4'b1111, 1'b0, 1'b0);
        step("clear");

        // Two SHL then reset while shifting.
        drive(1'b0, 1'b1, 3'b010, 4'b0000, 1'b0, 1'b1);
        step("shl_a");
        step("shl_b");
        drive(1'b1, 1'b1, 3'b010, 4'b0000, 1'b0, 1'b1);
        step("rst_mid");
        chk("rst_mid_done", int'(done), 0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
                  3'($urandom_range(0, 7)), 4'($urandom), 1'($urandom), 1'($urandom));
            step("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
